wb_regfile: RTL and testbench

- Consumer end of the MEM/WB pipeline register: takes the registered WB-stage bundle, selects the writeback value, and commits it to a 32x32 integer register file.
- Serves the two ID-stage read ports with write-first bypass. Exports the selected writeback value for EX-stage forwarding.
- Maintains a retired-instruction counter.
- Sits between the MEM/WB pipeline register and the ID/EX decode logic.

---
 rtl/wb_regfile_pkg.sv | 17 +
 rtl/wb_regfile_bypass_port.sv | 42 ++++
 rtl/wb_regfile.sv | 95 +++++++++
 tb/tb_wb_regfile.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// -----------------------------------------------------------------------------
// wb_regfile_pkg
// Shared pipeline definitions for the writeback / register-file slice.
//   PIPE_XLEN   : default datapath width
//   REG_AW      : register index width (32 architectural registers)
//   WB_SEL_*    : encodings of the wb_sel_data writeback source select
// -----------------------------------------------------------------------------
package wb_regfile_pkg;
    localparam int PIPE_XLEN = 32;
    localparam int REG_AW    = 5;
    localparam int NREGS     = 1 << REG_AW;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;
    localparam logic [1:0] WB_SEL_IMM  = 2'b11;
endpackage

// File: rtl/wb_regfile_bypass_port.sv
// -----------------------------------------------------------------------------
// regfile_bypass_port
// One combinational register-file read port with write-first bypass.
//   i_rs      : read index
//   i_regs    : flattened storage x1..x31 (x0 has no storage)
//   i_we      : a commit to i_wb_rd happens on the coming edge
//   i_wb_rd   : destination index of that commit
//   i_wb_data : value being committed
//   o_data    : read result (0 for x0, bypassed value on a same-cycle hit)
// -----------------------------------------------------------------------------
module regfile_bypass_port
    import wb_regfile_pkg::*;
#(
    parameter int XLEN = PIPE_XLEN
) (
    input  logic [REG_AW-1:0]                  i_rs,
    input  logic [NREGS-1:1][XLEN-1:0]         i_regs,
    input  logic                               i_we,
    input  logic [REG_AW-1:0]                  i_wb_rd,
    input  logic [XLEN-1:0]                    i_wb_data,
    output logic [XLEN-1:0]                    o_data
);

    logic [XLEN-1:0] w_stored;

    // Explicit select over x1..x31 keeps index 0 from ever addressing storage.
    always_comb begin
        w_stored = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (i_rs == REG_AW'(i)) w_stored = i_regs[i];
        end
    end

    always_comb begin
        o_data = w_stored;
        if (i_rs == '0)
            o_data = '0;
        else if (i_we && (i_rs == i_wb_rd))
            o_data = i_wb_data;
    end

endmodule

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
// Consumer end of the MEM/WB register: selects the writeback value, commits it
// to the 32x32 integer register file, serves two ID read ports with
// write-first bypass, exports the writeback value for EX forwarding and
// counts retired instructions.
//   clk, rst          : clock, asynchronous active-high reset
//   wb_*              : registered WB-stage bundle
//   id_rs1/id_rs2     : read indices; id_rs1_data/id_rs2_data results
//   wb_data/wb_fwd_en : forwarding value and its liveness
//   instret           : retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int XLEN = PIPE_XLEN,
    parameter int PCW  = 12,
    parameter int CNTW = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PCW-1:0]       wb_pc4,
    input  logic [XLEN-1:0]      wb_ALUout,
    input  logic [XLEN-1:0]      wb_loaddata,
    input  logic [XLEN-1:0]      wb_imm,
    input  logic [REG_AW-1:0]    wb_rd,
    input  logic                 wb_wr_en,
    input  logic [1:0]           wb_sel_data,
    input  logic                 wb_valid,
    input  logic [REG_AW-1:0]    id_rs1,
    input  logic [REG_AW-1:0]    id_rs2,
    output logic [XLEN-1:0]      id_rs1_data,
    output logic [XLEN-1:0]      id_rs2_data,
    output logic [XLEN-1:0]      wb_data,
    output logic                 wb_fwd_en,
    output logic [CNTW-1:0]      instret
);

    logic [NREGS-1:1][XLEN-1:0] r_regs;
    logic [CNTW-1:0]            r_instret;
    logic [XLEN-1:0]            w_wb_data;
    logic                       w_we;

    always_comb begin
        w_wb_data = wb_ALUout;
        case (wb_sel_data)
            WB_SEL_ALU:  w_wb_data = wb_ALUout;
            WB_SEL_LOAD: w_wb_data = wb_loaddata;
            WB_SEL_PC4:  w_wb_data = {{(XLEN-PCW){1'b0}}, wb_pc4};
            WB_SEL_IMM:  w_wb_data = wb_imm;
            default:     w_wb_data = wb_ALUout;
        endcase
    end

    // Bubbles and x0 destinations never write or forward.
    assign w_we = wb_wr_en && wb_valid && (wb_rd != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_regs <= '0;
        else if (w_we)
            r_regs[wb_rd] <= w_wb_data;
    end

    // Counts every valid WB instruction, including stores and branches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_instret <= '0;
        else if (wb_valid)
            r_instret <= r_instret + CNTW'(1);
    end

    regfile_bypass_port #(.XLEN(XLEN)) u_port1 (
        .i_rs      (id_rs1),
        .i_regs    (r_regs),
        .i_we      (w_we),
        .i_wb_rd   (wb_rd),
        .i_wb_data (w_wb_data),
        .o_data    (id_rs1_data)
    );

    regfile_bypass_port #(.XLEN(XLEN)) u_port2 (
        .i_rs      (id_rs2),
        .i_regs    (r_regs),
        .i_we      (w_we),
        .i_wb_rd   (wb_rd),
        .i_wb_data (w_wb_data),
        .o_data    (id_rs2_data)
    );

    assign wb_data   = w_wb_data;
    assign wb_fwd_en = w_we;
    assign instret   = r_instret;

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] wb_pc4 = '0;
    logic [31:0] wb_ALUout = '0, wb_loaddata = '0, wb_imm = '0;
    logic [4:0]  wb_rd = '0;
    logic        wb_wr_en = 1'b0;
    logic [1:0]  wb_sel_data = '0;
    logic        wb_valid = 1'b0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0;
    logic [31:0] id_rs1_data, id_rs2_data, wb_data;
    logic        wb_fwd_en;
    logic [31:0] instret;
    // Second instance with a 3-bit counter exercises wrap-around quickly.
    logic [31:0] s_rs1_data, s_rs2_data, s_wb_data;
    logic        s_fwd_en;
    logic [2:0]  s_instret;

    int checks = 0;
    int failures = 0;

    // Reference model
    logic [31:0] ref_regs [32];
    logic [31:0] ref_instret;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk(clk), .rst(rst), .wb_pc4(wb_pc4), .wb_ALUout(wb_ALUout),
        .wb_loaddata(wb_loaddata), .wb_imm(wb_imm), .wb_rd(wb_rd),
        .wb_wr_en(wb_wr_en), .wb_sel_data(wb_sel_data), .wb_valid(wb_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .wb_data(wb_data), .wb_fwd_en(wb_fwd_en),
        .instret(instret)
    );

    wb_regfile #(.CNTW(3)) dut_small (
        .clk(clk), .rst(rst), .wb_pc4(wb_pc4), .wb_ALUout(wb_ALUout),
        .wb_loaddata(wb_loaddata), .wb_imm(wb_imm), .wb_rd(wb_rd),
        .wb_wr_en(wb_wr_en), .wb_sel_data(wb_sel_data), .wb_valid(wb_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_data(s_rs1_data),
        .id_rs2_data(s_rs2_data), .wb_data(s_wb_data), .wb_fwd_en(s_fwd_en),
        .instret(s_instret)
    );

    function automatic logic [31:0] exp_wbd();
        case (wb_sel_data)
            2'd0: return wb_ALUout;
            2'd1: return wb_loaddata;
            2'd2: return {20'd0, wb_pc4};
            default: return wb_imm;
        endcase
    endfunction

    function automatic logic exp_we();
        return wb_wr_en && wb_valid && (wb_rd != 0);
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] idx);
        if (idx == 0) return 32'd0;
        if (exp_we() && idx == wb_rd) return exp_wbd();
        return ref_regs[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
        ref_instret = 32'd0;
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] rd,
                         input logic [1:0] sel, input logic [31:0] alu,
                         input logic [4:0] rs1, input logic [4:0] rs2);
        wb_valid = v; wb_wr_en = we; wb_rd = rd; wb_sel_data = sel;
        wb_ALUout = alu; id_rs1 = rs1; id_rs2 = rs2;
    endtask

    // Clock edge with model update; returns at posedge+1.
    task automatic commit_edge();
        logic        we_s;
        logic [4:0]  rd_s;
        logic [31:0] d_s;
        logic        v_s;
        we_s = exp_we(); rd_s = wb_rd; d_s = exp_wbd(); v_s = wb_valid;
        @(posedge clk);
        if (we_s) ref_regs[rd_s] = d_s;
        if (v_s) ref_instret = ref_instret + 32'd1;
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (instret !== 32'd0) begin
            failures++; $display("FAIL reset_instret got=%h exp=%h", instret, 32'd0);
        end
        drive(1, 1, 5'd5, 2'd0, 32'hDEADBEEF, 5'd5, 5'd0);
        commit_edge();
        drive(0, 0, 5'd0, 2'd0, 32'd0, 5'd5, 5'd0);
        #1;
        checks++;
        if (id_rs1_data !== 32'hDEADBEEF) begin
            failures++; $display("FAIL reset_prewrite got=%h exp=%h", id_rs1_data, 32'hDEADBEEF);
        end
        // Pulse reset mid-cycle; effect must be immediate.
        #2 rst = 1'b1; model_reset();
        #1;
        checks++;
        if (id_rs1_data !== 32'd0) begin
            failures++; $display("FAIL reset_async_rd got=%h exp=%h", id_rs1_data, 32'd0);
        end
        checks++;
        if (instret !== 32'd0) begin
            failures++; $display("FAIL reset_async_cnt got=%h exp=%h", instret, 32'd0);
        end
        rst = 1'b0;
        // Reset asserted across an edge with a pending write: write lost.
        @(posedge clk); #1;
        drive(1, 1, 5'd6, 2'd0, 32'h00001234, 5'd6, 5'd6);
        #7 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 0, 5'd0, 2'd0, 32'd0, 5'd6, 5'd0);
        #1;
        checks++;
        if (id_rs1_data !== 32'd0 || instret !== 32'd0) begin
            failures++; $display("FAIL reset_wins rd=%h cnt=%h exp=0", id_rs1_data, instret);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_source_select();
        logic [31:0] exp_vals [4];
        logic [31:0] cnt0;
        exp_vals[0] = 32'h11; exp_vals[1] = 32'h22;
        exp_vals[2] = 32'h000000A4; exp_vals[3] = 32'h12345000;
        wb_loaddata = 32'h22; wb_pc4 = 12'h0A4; wb_imm = 32'h12345000;
        cnt0 = ref_instret;
        for (int s = 0; s < 4; s++) begin
            drive(1, 1, 5'd7, 2'(s), 32'h11, 5'd0, 5'd0);
            commit_edge();
            drive(0, 0, 5'd0, 2'd0, 32'd0, 5'd7, 5'd7);
            #1;
            checks++;
            if (id_rs1_data !== exp_vals[s] || id_rs2_data !== exp_vals[s]) begin
                failures++;
                $display("FAIL sel_%0d got=%h/%h exp=%h", s, id_rs1_data, id_rs2_data, exp_vals[s]);
            end
        end
        checks++;
        if (instret !== cnt0 + 32'd4) begin
            failures++; $display("FAIL sel_instret got=%h exp=%h", instret, cnt0 + 32'd4);
        end
    endtask

    task automatic test_bypass();
        drive(1, 1, 5'd9, 2'd0, 32'hCAFE0001, 5'd9, 5'd9);
        #1;
        checks++;
        if (id_rs1_data !== 32'hCAFE0001 || id_rs2_data !== 32'hCAFE0001 || wb_fwd_en !== 1'b1) begin
            failures++;
            $display("FAIL bypass got=%h/%h fwd=%b exp=cafe0001 fwd=1", id_rs1_data, id_rs2_data, wb_fwd_en);
        end
        commit_edge();
    endtask

    task automatic test_x0();
        logic [31:0] cnt0;
        cnt0 = ref_instret;
        drive(1, 1, 5'd0, 2'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        #1;
        checks++;
        if (id_rs1_data !== 32'd0 || wb_fwd_en !== 1'b0) begin
            failures++; $display("FAIL x0_write got=%h fwd=%b exp=0 fwd=0", id_rs1_data, wb_fwd_en);
        end
        commit_edge();
        drive(0, 0, 5'd0, 2'd0, 32'd0, 5'd0, 5'd0);
        #1;
        checks++;
        if (id_rs1_data !== 32'd0 || instret !== cnt0 + 32'd1) begin
            failures++; $display("FAIL x0_after rd=%h cnt=%h exp=0/%h", id_rs1_data, instret, cnt0 + 32'd1);
        end
    endtask

    task automatic test_bubble();
        logic [31:0] cnt0;
        drive(1, 1, 5'd3, 2'd0, 32'h77, 5'd0, 5'd0);
        commit_edge();
        cnt0 = ref_instret;
        drive(0, 1, 5'd3, 2'd0, 32'h55, 5'd3, 5'd3);
        #1;
        checks++;
        if (id_rs1_data !== 32'h77 || wb_fwd_en !== 1'b0) begin
            failures++; $display("FAIL bubble_bypass got=%h fwd=%b exp=77 fwd=0", id_rs1_data, wb_fwd_en);
        end
        commit_edge();
        checks++;
        if (id_rs2_data !== 32'h77 || instret !== cnt0) begin
            failures++; $display("FAIL bubble_after rd=%h cnt=%h exp=77/%h", id_rs2_data, instret, cnt0);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            wb_valid    = ($urandom_range(0, 3) != 0);
            wb_wr_en    = ($urandom_range(0, 3) != 0);
            wb_rd       = 5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
            wb_sel_data = 2'($urandom_range(0, 3));
            wb_ALUout   = $urandom; wb_loaddata = $urandom; wb_imm = $urandom;
            wb_pc4      = 12'($urandom);
            id_rs1      = 5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
            id_rs2      = 5'($urandom_range(0, 1) ? wb_rd : $urandom_range(0, 31));
            #1;
            checks++;
            if (id_rs1_data !== exp_read(id_rs1) || id_rs2_data !== exp_read(id_rs2)) begin
                failures++;
                $display("FAIL rand_read n=%0d got=%h/%h exp=%h/%h", n, id_rs1_data, id_rs2_data,
                         exp_read(id_rs1), exp_read(id_rs2));
            end
            checks++;
            if (wb_data !== exp_wbd() || wb_fwd_en !== exp_we()) begin
                failures++;
                $display("FAIL rand_wb n=%0d got=%h/%b exp=%h/%b", n, wb_data, wb_fwd_en, exp_wbd(), exp_we());
            end
            checks++;
            if (instret !== ref_instret || s_instret !== ref_instret[2:0]) begin
                failures++;
                $display("FAIL rand_cnt n=%0d got=%h/%h exp=%h", n, instret, s_instret, ref_instret);
            end
            commit_edge();
        end
    endtask

    task automatic test_wrap();
        logic [2:0] exp7;
        exp7 = 3'd7;
        #2 rst = 1'b1; model_reset();
        #1 rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 7; i++) begin
            drive(1, 0, 5'd0, 2'd0, 32'd0, 5'd0, 5'd0);
            commit_edge();
        end
        checks++;
        if (s_instret !== exp7 || instret !== 32'd7) begin
            failures++; $display("FAIL wrap_pre got=%h/%h exp=7/7", s_instret, instret);
        end
        commit_edge();
        checks++;
        if (s_instret !== 3'd0 || instret !== 32'd8) begin
            failures++; $display("FAIL wrap got=%h/%h exp=0/8", s_instret, instret);
        end
        drive(0, 0, 5'd0, 2'd0, 32'd0, 5'd0, 5'd0);
    endtask

    initial begin
        model_reset();
        #12 rst = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_source_select();
        test_bypass();
        test_x0();
        test_bubble();
        test_random();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
